pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be: LANES, default 1, number of parallel issue lanes (1..4); DATA_W, default 32, per-lane payload width; STALL_W, default 6, stall bus width; STAGE, default 3, stall bus index of this stage (0..STALL_W-2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 stall  input  STALL_W  stall bus from ctrl; Stop=1, NoStop=0.
REQ-005 flush  input  1  kill all lanes (redirect).
REQ-006 flush_young  input  1  kill lanes 1..LANES-1 only (older lane 0 survives).
REQ-007 in_valid  input  LANES  per-lane valid from upstream stage.
REQ-008 in_data  input  LANES*DATA_W  per-lane payload, lane 0 in LSBs.
REQ-009 out_valid  output  LANES  registered per-lane valid.
REQ-010 out_data  output  LANES*DATA_W  registered payload.
REQ-011 bubble_cnt  output  16  bubble counter (present only when configured, REQ-025).

Function
REQ-012 Register update SHALL be evaluated on each rising clk edge in priority order: flush, flush_young, bubble, load, hold.
REQ-013 flush=1 SHALL clear every out_valid bit and zero out_data, regardless of stall.
REQ-014 flush_young=1 with flush=0 SHALL clear out_valid[LANES-1:1] and zero those lanes' data; lane 0 SHALL then follow REQ-015..017; with LANES=1 flush_young SHALL have no effect.
REQ-015 Bubble: stall[STAGE]=Stop and stall[STAGE+1]=NoStop SHALL clear all out_valid and zero out_data.
REQ-016 Load: stall[STAGE]=NoStop SHALL capture in_valid into out_valid and in_data into out_data in one cycle (latency 1).
REQ-017 Hold: stall[STAGE]=Stop and stall[STAGE+1]=Stop SHALL retain out_valid and out_data unchanged.
REQ-018 Lane data whose in_valid bit is 0 at load SHALL be captured as zero.
REQ-019 Lane valids SHALL stay contiguous: if in_valid[k]=0 then lanes above k SHALL load as invalid irrespective of in_valid.
REQ-020 Stall bits outside STAGE and STAGE+1 SHALL not affect this block.

Reset
REQ-021 rst=0 SHALL immediately and asynchronously force out_valid=0, out_data=0 and bubble_cnt=0.
REQ-022 Reset deassertion SHALL occur synchronously to clk in the instantiating design; the first edge after release SHALL follow REQ-012.
REQ-023 rst asserted mid-hold or mid-flush SHALL discard held contents; no state survives reset.

Configuration
REQ-024 Macro PIPE_BUBBLE_CNT_EN SHALL control the bubble counter.
REQ-025 With PIPE_BUBBLE_CNT_EN defined: bubble_cnt SHALL increment by 1 on each edge where REQ-015 or REQ-013 applies, saturate at 16'hFFFF, and never wrap.
REQ-026 Without PIPE_BUBBLE_CNT_EN: bubble_cnt port SHALL be absent and no counter logic SHALL be synthesised; all other behaviour SHALL be identical.

Structure
REQ-027 Stop/NoStop, RstEnable-style level constants and stall bus width SHALL come from the shared defines package; no local redefinition.
REQ-028 The saturating counter SHALL be a sub-module sat_counter (WIDTH parameter, inc, clr, count), instantiated only under PIPE_BUBBLE_CNT_EN.
REQ-029 Per-lane mask (contiguity, flush_young) SHALL be one combinational block feeding a single registered always block.

Verification
REQ-030 LANES=2, DATA_W=32, STAGE=3: stall=0, in_valid=2'b11, in_data={32'hB,32'hA} -> next cycle out_valid=2'b11, out_data={B,A}.
REQ-031 stall[3]=1, stall[4]=0 with valid contents -> next cycle out_valid=0, out_data=0, bubble_cnt +1 (macro on).
REQ-032 stall[3]=1, stall[4]=1 for 5 cycles while in_data changes -> out_data unchanged all 5 cycles, bubble_cnt unchanged.
REQ-033 flush_young=1, stall=0, in_valid=2'b11, in_data={D,C} -> out_valid=2'b01, out_data={0,C}; flush=1 with stall[3]=stall[4]=1 -> out_valid=0.
REQ-034 in_valid=2'b10 -> out_valid=2'b00 (contiguity); rst=0 pulse between clock edges -> outputs 0 before next edge.
REQ-035 Macro on: force 65540 consecutive bubbles -> bubble_cnt=16'hFFFF, stays there; macro off -> build has no bubble_cnt port.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared stall/reset level constants and widths for the pipeline stage register.
// Imported by pipe_stage_reg and its optional bubble counter.
package pipe_stage_reg_pkg;

    localparam logic STOP        = 1'b1;
    localparam logic NO_STOP     = 1'b0;
    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    localparam int STALL_W_DEF = 6;
    localparam int CNT_W       = 16;
    localparam int MAX_LANES   = 4;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
// Used as the bubble counter of pipe_stage_reg when PIPE_BUBBLE_CNT_EN is defined.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register with flush, young-lane flush, bubble and hold.
// Optional bubble counter enabled by defining PIPE_BUBBLE_CNT_EN (port absent otherwise).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int DATA_W  = 32,
    parameter int STALL_W = STALL_W_DEF,
    parameter int STAGE   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      flush_young,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES*DATA_W-1:0]   out_data
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]          bubble_cnt
`endif
);

    logic                     bubble;
    logic                     load;
    logic                     chain;
    logic [LANES-1:0]         keep;
    logic [LANES-1:0]         valid_next;
    logic [LANES*DATA_W-1:0]  data_next;
    logic                     stall_unused;

    assign bubble = (stall[STAGE] == STOP) && (stall[STAGE+1] == NO_STOP);
    assign load   = (stall[STAGE] == NO_STOP);

    // Only STAGE and STAGE+1 of the stall bus steer this register.
    assign stall_unused = ^stall;

    // keep[k] is set only while every lane at or below k is valid, so a gap
    // in in_valid invalidates all younger lanes.
    always_comb begin
        valid_next = out_valid;
        data_next  = out_data;
        keep       = '0;
        chain      = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            chain   = chain & in_valid[k];
            keep[k] = chain;
            if (flush || bubble || (flush_young && (k != 0))) begin
                valid_next[k]                  = 1'b0;
                data_next[k*DATA_W +: DATA_W]  = '0;
            end else if (load) begin
                valid_next[k]                  = keep[k];
                data_next[k*DATA_W +: DATA_W]  = keep[k] ? in_data[k*DATA_W +: DATA_W]
                                                         : {DATA_W{1'b0}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= valid_next;
            out_data  <= data_next;
        end
    end

`ifdef PIPE_BUBBLE_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush || bubble),
        .clr   (1'b0),
        .count (bubble_cnt)
    );
`endif

endmodule
